// File: rtl/wbm_pkg.sv
// Shared definitions for the Wishbone block-copy engine: FSM state
// encoding, bus constants and the word-alignment helper.
package wbm_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    FIN  = 2'd3
  } state_e;

  // Every access is a full 32-bit word.
  localparam logic [3:0]  WB_SEL_ALL = 4'b1111;

  // Byte distance between consecutive words.
  localparam logic [31:0] ADR_INC    = 32'd4;

  // Drop the byte offset; the engine only ever moves whole words.
  function automatic logic [31:0] word_align(input logic [31:0] adr);
    return {adr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/wbm_timeout.sv
// Bus-access watchdog. Counts the cycles an access spends waiting for an
// acknowledge and flags the cycle in which the wait reaches TIMEOUT.
// TIMEOUT = 0 disables the watchdog.
module wbm_timeout #(
  parameter int TIMEOUT = 255
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic clr,     // no access in flight; restart the count
  input  logic inc,     // access in flight and not acknowledged this cycle
  output logic expire   // this unacknowledged cycle is the TIMEOUT-th one
);

  localparam int            CW   = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  logic [CW-1:0] cnt_q;

  // Wait-cycle counter, restarted whenever the strobe is low.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    // NOTE: registers are updated with non-blocking assignments so every
    // flop samples pre-edge values regardless of statement order.
    if (!sys_rst_n) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (inc) begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  // Expire is combinational so the engine can drop the strobe on the very
  // edge that closes the TIMEOUT-th waiting cycle.
  assign expire = (TIMEOUT != 0) && inc && (cnt_q == LAST);

endmodule

// File: rtl/wbm_copy_engine.sv
// Wishbone classic-cycle master that copies a block of words from a source
// region to a destination region, or fills the destination with a constant.
// Every access is a single strobe followed by at least one idle cycle.
module wbm_copy_engine
  import wbm_pkg::*;
#(
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 255
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  // job control
  input  logic             start,
  input  logic             fill,
  input  logic [31:0]      src_adr,
  input  logic [31:0]      dst_adr,
  input  logic [CNT_W-1:0] count,
  input  logic [31:0]      pattern,
  output logic             busy,
  output logic             done,
  output logic             err,
  // Wishbone master
  output logic [31:0]      wb_adr_o,
  output logic [31:0]      wb_dat_o,
  input  logic [31:0]      wb_dat_i,
  output logic [3:0]       wb_sel_o,
  output logic             wb_stb_o,
  output logic             wb_cyc_o,
  output logic             wb_we_o,
  input  logic             wb_ack_i
);

  state_e           state_q;
  logic [31:0]      src_q;      // next word to read
  logic [31:0]      dst_q;      // next word to write
  logic [31:0]      data_q;     // captured read word, or the fill pattern
  logic [CNT_W-1:0] rem_q;      // words still to be written
  logic             fill_q;     // job is a fill
  logic             abort_q;    // job is ending because of a timeout
  logic             tmo_expire;

  wbm_timeout #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .clr       (~wb_stb_o),
    .inc       (wb_stb_o & ~wb_ack_i),
    .expire    (tmo_expire)
  );

  // Job sequencer: latches a job, issues one bus access at a time and
  // reports completion. All outputs are driven from flops.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      // NOTE: bus outputs are cleared asynchronously so a reset in the
      // middle of an access releases the bus without waiting for a clock.
      state_q  <= IDLE;
      src_q    <= '0;
      dst_q    <= '0;
      data_q   <= '0;
      rem_q    <= '0;
      fill_q   <= 1'b0;
      abort_q  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      wb_adr_o <= '0;
      wb_dat_o <= '0;
      wb_sel_o <= '0;
      wb_stb_o <= 1'b0;
      wb_cyc_o <= 1'b0;
      wb_we_o  <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;

      case (state_q)
        IDLE: begin
          if (start) begin
            src_q   <= word_align(src_adr);
            dst_q   <= word_align(dst_adr);
            rem_q   <= count;
            fill_q  <= fill;
            data_q  <= pattern;
            abort_q <= 1'b0;
            busy    <= 1'b1;
            if (count == '0) begin
              state_q <= FIN;
            end else if (fill) begin
              // First fill write goes out straight away.
              state_q  <= WR;
              wb_stb_o <= 1'b1;
              wb_cyc_o <= 1'b1;
              wb_we_o  <= 1'b1;
              wb_sel_o <= WB_SEL_ALL;
              wb_adr_o <= word_align(dst_adr);
              wb_dat_o <= pattern;
            end else begin
              // First copy read goes out straight away.
              state_q  <= RD;
              wb_stb_o <= 1'b1;
              wb_cyc_o <= 1'b1;
              wb_we_o  <= 1'b0;
              wb_sel_o <= WB_SEL_ALL;
              wb_adr_o <= word_align(src_adr);
            end
          end
        end

        RD: begin
          if (!wb_stb_o) begin
            // Idle cycle is over: issue the read.
            wb_stb_o <= 1'b1;
            wb_cyc_o <= 1'b1;
            wb_we_o  <= 1'b0;
            wb_sel_o <= WB_SEL_ALL;
            wb_adr_o <= src_q;
          end else if (wb_ack_i) begin
            data_q   <= wb_dat_i;
            wb_stb_o <= 1'b0;
            wb_cyc_o <= 1'b0;
            wb_sel_o <= '0;
            state_q  <= WR;
          end else if (tmo_expire) begin
            wb_stb_o <= 1'b0;
            wb_cyc_o <= 1'b0;
            wb_sel_o <= '0;
            abort_q  <= 1'b1;
            state_q  <= FIN;
          end
        end

        WR: begin
          if (!wb_stb_o) begin
            // Idle cycle is over: issue the write.
            wb_stb_o <= 1'b1;
            wb_cyc_o <= 1'b1;
            wb_we_o  <= 1'b1;
            wb_sel_o <= WB_SEL_ALL;
            wb_adr_o <= dst_q;
            wb_dat_o <= data_q;
          end else if (wb_ack_i) begin
            wb_stb_o <= 1'b0;
            wb_cyc_o <= 1'b0;
            wb_we_o  <= 1'b0;
            wb_sel_o <= '0;
            src_q    <= src_q + ADR_INC;
            dst_q    <= dst_q + ADR_INC;
            rem_q    <= rem_q - CNT_W'(1);
            if (rem_q == CNT_W'(1)) begin
              state_q <= FIN;
            end else if (!fill_q) begin
              state_q <= RD;
            end
          end else if (tmo_expire) begin
            wb_stb_o <= 1'b0;
            wb_cyc_o <= 1'b0;
            wb_we_o  <= 1'b0;
            wb_sel_o <= '0;
            abort_q  <= 1'b1;
            state_q  <= FIN;
          end
        end

        FIN: begin
          done    <= 1'b1;
          err     <= abort_q;
          abort_q <= 1'b0;
          busy    <= 1'b0;
          state_q <= IDLE;
        end

        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/wbm_copy_engine.md
Name: wbm_copy_engine

Overview:
- Wishbone classic-cycle bus master (initiator) that moves a block of 32-bit words. In copy mode it reads each word from a source region and writes it to a destination region; in fill mode it writes a constant pattern.
- Drives on-chip Wishbone slaves such as the monitor RAM and CSR-mapped memories.
- Used for boot-time ROM-to-RAM copies and for memory clearing, so the CPU does not have to do them.
- Controlled by a simple start/busy/done handshake from a CSR front end.

Parameters:
- CNT_W, 16, width of the word-count input; maximum block is 2^CNT_W-1 words.
- TIMEOUT, 255, number of cycles to wait for wb_ack_i before aborting; 0 disables the timeout.

Ports:
- sys_clk  in  1  system clock.
- sys_rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- fill  in  1  1 = fill mode, 0 = copy mode; sampled with start.
- src_adr  in  32  source byte address; bits [1:0] are ignored.
- dst_adr  in  32  destination byte address; bits [1:0] are ignored.
- count  in  CNT_W  number of words to transfer.
- pattern  in  32  fill value; sampled with start.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse at the end of a job.
- err  out  1  one-cycle pulse, coincident with done, when a job ends by timeout.
- wb_adr_o  out  32  bus address.
- wb_dat_o  out  32  write data.
- wb_dat_i  in  32  read data.
- wb_sel_o  out  4  byte selects; always 4'b1111 while stb is high.
- wb_stb_o  out  1  strobe.
- wb_cyc_o  out  1  cycle.
- wb_we_o  out  1  write enable.
- wb_ack_i  in  1  slave acknowledge.

Behaviour:
- Reset (async, sys_rst_n=0):
  - State goes to IDLE.
  - All outputs are 0, including wb_adr_o and wb_dat_o.
  - Internal address, count and timeout registers are cleared.
  - Reset mid-transfer drops cyc/stb immediately; no done pulse follows.
- All outputs are registered. wb_cyc_o always equals wb_stb_o (no bursts, no held bus between accesses).
- States:
  - IDLE: on start, latch the job inputs into internal registers.
    - If count==0: go to FIN.
    - Else if fill: go to WR.
    - Else: go to RD.
  - RD: cyc=stb=1, we=0, adr={src[31:2],2'b00}.
    - On wb_ack_i: capture wb_dat_i into the data register, drop stb/cyc on the next edge, go to WR.
  - WR: cyc=stb=1, we=1, adr={dst[31:2],2'b00}, dat = captured data (copy) or pattern (fill).
    - On wb_ack_i: src += 4 and dst += 4 (wrap modulo 2^32), remaining -= 1, drop stb/cyc.
    - If remaining becomes 0: go to FIN.
    - Else: go to RD (copy) or stay in WR (fill).
  - FIN: done=1 for one cycle, busy=0, then go to IDLE.
- Bus-idle rule: stb is deasserted for at least one cycle after every ack. This is required by slaves that gate on ~ack.
- Latency:
  - start accepted in cycle N: busy=1 and the first stb in cycle N+1.
  - Zero-wait slave acking one cycle after stb: copy costs 4 cycles per word, fill costs 2 cycles per word.
  - done is asserted the cycle after the final write ack is sampled, plus one cycle.
- Timeout:
  - A counter clears whenever stb rises and increments every cycle stb=1 and ack=0.
  - When it reaches TIMEOUT: drop cyc/stb, go to FIN, and pulse err with done.
  - Remaining words are abandoned.
- start while busy is ignored; it does not queue.
- wb_ack_i while stb=0 is ignored.
- wb_dat_i is sampled only on an ack in RD.

Decomposition:
- Shared package wbm_pkg:
  - state encoding constants (IDLE, RD, WR, FIN);
  - WB_SEL_ALL=4'b1111;
  - address increment constant 4.
- One natural sub-module: wbm_timeout (reset-able cycle counter with expire flag, parameterised by TIMEOUT).
- The rest (FSM, address/count registers) stays in a single module.

Test Plan:
- Copy, count=3, src=0x100, dst=0x800, slave memory 0x100..0x108 = A1,B2,C3 -> reads at 0x100, 0x104, 0x108 with we=0; writes A1,B2,C3 to 0x800, 0x804, 0x808; done pulse 12 cycles after the first stb; busy low afterwards.
- Fill, count=4, dst=0x0, pattern=0xDEADBEEF -> 4 writes at 0x0..0xC with sel=1111; no read cycles; stb low for ≥1 cycle between writes.
- count=0 -> no stb ever; done pulses 2 cycles after start; err=0.
- Slave never acks, TIMEOUT=8 -> stb held 8 cycles then dropped; done=err=1 in the same cycle; next start accepted normally.
- sys_rst_n asserted low mid-WR -> cyc/stb/we/busy go 0 asynchronously; no done pulse; a fresh job after release completes correctly.
- start pulsed while busy; dst=0xFFFFFFFC, fill count=2 -> second start ignored; addresses 0xFFFFFFFC then 0x00000000 (wrap).
